// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-granular arbiter sharing one async FIFO write port among NREQ sources.
// Guards the FIFO against runaway packets (MAXLEN cap) and stalled sources (TMO idle timeout).
module fifo_wr_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DSIZE  = 8,
  parameter int unsigned IDW    = 2,
  parameter int unsigned MAXLEN = 16,
  parameter int unsigned TMO    = 64
) (
  input  logic                  wclk_i,
  input  logic                  wrst_ni,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ-1:0]       req_last_i,
  input  logic [NREQ*DSIZE-1:0] req_data_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  winc_o,
  output logic [DSIZE-1:0]      wdata_o,
  input  logic                  wfull_i,
  input  logic                  awfull_i,
  output logic                  gnt_vld_o,
  output logic [IDW-1:0]        gnt_id_o,
  output logic                  pkt_done_o,
  output logic                  len_err_o,
  output logic                  tmo_err_o
);

  localparam int unsigned BW = $clog2(MAXLEN + 1);
  localparam int unsigned TW = $clog2(TMO + 1);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] last_id_q, last_id_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]  idle_cnt_q, idle_cnt_d;
  logic           pkt_done_q, pkt_done_d;
  logic           len_err_q, len_err_d;
  logic           tmo_err_q, tmo_err_d;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] cand;

  // Scan starts just after the last served requester, so it has lowest priority next.
  always_comb begin
    win_found = 1'b0;
    win_id    = last_id_q;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_id_q) + k) % NREQ);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    gnt_id_d    = gnt_id_q;
    beat_cnt_d  = beat_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    pkt_done_d  = 1'b0;
    len_err_d   = 1'b0;
    tmo_err_d   = 1'b0;
    req_ready_o = '0;
    winc_o      = 1'b0;
    wdata_o     = '0;

    unique case (state_q)
      StIdle: begin
        if (win_found && !awfull_i) begin
          state_d    = StXfer;
          gnt_id_d   = win_id;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      StXfer: begin
        req_ready_o[gnt_id_q] = ~wfull_i;
        wdata_o               = req_data_i[32'(gnt_id_q) * DSIZE +: DSIZE];
        winc_o                = req_valid_i[gnt_id_q] & ~wfull_i;
        if (winc_o) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          idle_cnt_d = '0;
          if (req_last_i[gnt_id_q]) begin
            state_d    = StIdle;
            last_id_d  = gnt_id_q;
            pkt_done_d = 1'b1;
          end else if (beat_cnt_q == BW'(MAXLEN - 1)) begin
            state_d   = StIdle;
            last_id_d = gnt_id_q;
            len_err_d = 1'b1;
          end
        end else if (!req_valid_i[gnt_id_q]) begin
          // Stalls on wfull with valid high are not idleness and leave the counter alone.
          idle_cnt_d = idle_cnt_q + 1'b1;
          if (idle_cnt_d == TW'(TMO)) begin
            state_d   = StIdle;
            last_id_d = gnt_id_q;
            tmo_err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wclk_i or negedge wrst_ni) begin
    if (!wrst_ni) begin
      state_q    <= StIdle;
      last_id_q  <= IDW'(NREQ - 1);
      gnt_id_q   <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      pkt_done_q <= 1'b0;
      len_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_id_q  <= last_id_d;
      gnt_id_q   <= gnt_id_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      pkt_done_q <= pkt_done_d;
      len_err_q  <= len_err_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign gnt_vld_o  = (state_q == StXfer);
  assign gnt_id_o   = gnt_id_q;
  assign pkt_done_o = pkt_done_q;
  assign len_err_o  = len_err_q;
  assign tmo_err_o  = tmo_err_q;

endmodule
